// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame constants and state encoding for encoder and decoder
package frame_pkg;

  localparam logic [7:0] STX1_DEFAULT  = 8'hFF;
  localparam logic [7:0] STX2_DEFAULT  = 8'h5A;
  localparam int         FRAME_LEN     = 16;
  localparam int         PAYLOAD_COUNT = 8;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_STX1 = 4'd1,
    S_STX2 = 4'd2,
    S_CH1  = 4'd3,
    S_CH2  = 4'd4,
    S_CH3  = 4'd5,
    S_CH4  = 4'd6,
    S_OFF1 = 4'd7,
    S_OFF2 = 4'd8,
    S_OFF3 = 4'd9,
    S_OFF4 = 4'd10,
    S_RSV  = 4'd11
  } state_t;

  // Index of the payload byte that follows the current state (CH1 = 0 ... OFF4 = 7).
  function automatic logic [2:0] payload_sel(input state_t s);
    logic [3:0] d;
    d = s - S_STX2;
    return d[2:0];
  endfunction

endpackage

// File: rtl/frame_snapshot.sv
// rtl/frame_snapshot.sv - 8x8-bit payload register bank with load and byte select
module frame_snapshot
  import frame_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [8*PAYLOAD_COUNT-1:0] load_data,
  input  logic [2:0]                 sel,
  output logic [7:0]                 data
);

  logic [7:0] bank [PAYLOAD_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PAYLOAD_COUNT; i++) bank[i] <= 8'h00;
    end else if (load) begin
      for (int i = 0; i < PAYLOAD_COUNT; i++) bank[i] <= load_data[8*i +: 8];
    end
  end

  assign data = bank[sel];

endmodule

// File: rtl/frame_encoder.sv
// rtl/frame_encoder.sv - serialises one 16-byte control frame per start into a valid/ready byte stream
module frame_encoder
  import frame_pkg::*;
#(
  parameter logic [7:0] STX1_BYTE = STX1_DEFAULT,
  parameter logic [7:0] STX2_BYTE = STX2_DEFAULT,
  parameter logic [7:0] RSV_BYTE  = 8'h00,
  parameter int         RSV_COUNT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] sink_CH1data,
  input  logic [7:0] sink_CH2data,
  input  logic [7:0] sink_CH3data,
  input  logic [7:0] sink_CH4data,
  input  logic [7:0] sink_offset1data,
  input  logic [7:0] sink_offset2data,
  input  logic [7:0] sink_offset3data,
  input  logic [7:0] sink_offset4data,
  input  logic       source_ready,
  output logic       source_data_valid,
  output logic [7:0] source_data,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [3:0] RSV_LAST = 4'(RSV_COUNT - 1);

  state_t     state;
  logic [3:0] rsv_cnt;
  logic [7:0] snap_byte;
  logic       snap_load;
  logic       xfer;

  assign xfer      = source_data_valid && source_ready;
  assign snap_load = (state == S_IDLE) && start;

  frame_snapshot u_snapshot (
    .clk       (clk),
    .reset     (reset),
    .load      (snap_load),
    .load_data ({sink_offset4data, sink_offset3data, sink_offset2data, sink_offset1data,
                 sink_CH4data, sink_CH3data, sink_CH2data, sink_CH1data}),
    .sel       (payload_sel(state)),
    .data      (snap_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      source_data_valid <= 1'b0;
      source_data       <= 8'h00;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      rsv_cnt           <= 4'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state             <= S_STX1;
          source_data       <= STX1_BYTE;
          source_data_valid <= 1'b1;
          busy              <= 1'b1;
        end
        S_STX1: if (xfer) begin
          state       <= S_STX2;
          source_data <= STX2_BYTE;
        end
        // Each transfer loads the byte belonging to the state being entered.
        S_STX2, S_CH1, S_CH2, S_CH3, S_CH4, S_OFF1, S_OFF2, S_OFF3: if (xfer) begin
          state       <= state_t'(state + 4'd1);
          source_data <= snap_byte;
        end
        S_OFF4: if (xfer) begin
          state       <= S_RSV;
          source_data <= RSV_BYTE;
          rsv_cnt     <= 4'd0;
        end
        S_RSV: if (xfer) begin
          if (rsv_cnt == RSV_LAST) begin
            state             <= S_IDLE;
            source_data_valid <= 1'b0;
            source_data       <= 8'h00;
            busy              <= 1'b0;
            frame_done        <= 1'b1;
            rsv_cnt           <= 4'd0;
          end else begin
            rsv_cnt <= rsv_cnt + 4'd1;
          end
        end
        default: begin
          state             <= S_IDLE;
          source_data_valid <= 1'b0;
          source_data       <= 8'h00;
          busy              <= 1'b0;
          rsv_cnt           <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_encoder.sv
// tb/tb_frame_encoder.sv - scoreboard bench for frame_encoder
module tb_frame_encoder;

  localparam int RSV_MAIN = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       ready = 1'b1;
  logic       ready1 = 1'b1;
  logic [7:0] ch [4];
  logic [7:0] off [4];
  logic       valid, busy, frame_done;
  logic [7:0] data;
  logic       valid1, busy1, frame_done1;
  logic [7:0] data1;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  logic [7:0] exp_q[$];
  bit         exp_last[$];
  bit         done_exp = 0;
  bit         hold_flag = 0;
  logic [7:0] held_data;

  always #5 clk = ~clk;

  frame_encoder u_dut (
    .clk(clk), .reset(reset), .start(start),
    .sink_CH1data(ch[0]), .sink_CH2data(ch[1]), .sink_CH3data(ch[2]), .sink_CH4data(ch[3]),
    .sink_offset1data(off[0]), .sink_offset2data(off[1]),
    .sink_offset3data(off[2]), .sink_offset4data(off[3]),
    .source_ready(ready), .source_data_valid(valid), .source_data(data),
    .busy(busy), .frame_done(frame_done)
  );

  frame_encoder #(.RSV_BYTE(8'hA5), .RSV_COUNT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .sink_CH1data(ch[0]), .sink_CH2data(ch[1]), .sink_CH3data(ch[2]), .sink_CH4data(ch[3]),
    .sink_offset1data(off[0]), .sink_offset2data(off[1]),
    .sink_offset3data(off[2]), .sink_offset4data(off[3]),
    .source_ready(ready1), .source_data_valid(valid1), .source_data(data1),
    .busy(busy1), .frame_done(frame_done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: sync pair, four channels, four offsets, reserved fill.
  function automatic void build_frame(input logic [7:0] rsv_byte, input int rsv_n,
                                      output logic [7:0] f[$]);
    f = {8'hFF, 8'h5A};
    for (int i = 0; i < 4; i++) f.push_back(ch[i]);
    for (int i = 0; i < 4; i++) f.push_back(off[i]);
    for (int i = 0; i < rsv_n; i++) f.push_back(rsv_byte);
  endfunction

  task automatic push_frame();
    logic [7:0] f[$];
    build_frame(8'h00, RSV_MAIN, f);
    foreach (f[i]) begin
      exp_q.push_back(f[i]);
      exp_last.push_back(i == f.size() - 1);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 4; i++) begin
      ch[i]  = 8'($urandom);
      off[i] = 8'($urandom);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    push_frame();
    @(posedge clk); #1;
    start = 1'b0;
    check("first_byte", {23'd0, valid, data}, {23'd0, 1'b1, 8'hFF});
  endtask

  task automatic wait_idle(input bit scramble);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 1000) begin
      @(posedge clk); #1;
      if (scramble) randomize_inputs();
      n++;
    end
    check("idle_timeout", 32'(n >= 1000), 32'd0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: ready = 1'b1;
      1: ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops expected bytes on every transfer and checks hold and frame_done.
  always @(negedge clk) begin
    if (reset) begin
      done_exp  = 0;
      hold_flag = 0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(done_exp));
      check("busy_valid", 32'(busy), 32'(valid));
      if (hold_flag) check("hold_data", {23'd0, valid, data}, {23'd0, 1'b1, held_data});
      done_exp = 0;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(data), 32'hFFFF_FFFF);
        end else begin
          check("byte", 32'(data), 32'(exp_q.pop_front()));
          done_exp = exp_last.pop_front();
        end
      end
      hold_flag = valid && !ready;
      held_data = data;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      ch[i]  = 8'h10 * 8'(i + 1);
      off[i] = 8'(i + 1);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);

    // Full-rate frame with exact timing.
    ready_mode = 0;
    pulse_start();
    repeat (15) @(posedge clk);
    #1 check("t1_busy_n16", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("t1_done_n17", 32'(frame_done), 32'd1);
    check("t1_busy_n17", 32'(busy), 32'd0);
    wait_idle(0);

    // Alternating ready.
    ready_mode = 1;
    pulse_start();
    wait_idle(0);

    // Ignored start and input change mid-frame.
    ready_mode = 0;
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    ch[0] = 8'h77;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(0);
    pulse_start();
    wait_idle(0);

    // Reset after byte 7.
    pulse_start();
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_last.delete();
    @(posedge clk); #1 reset = 1'b0;
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    pulse_start();
    wait_idle(0);

    // start held high: three back-to-back frames, 17 cycles apart.
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 3; k++) push_frame();
    repeat (51) @(posedge clk);
    #1 start = 1'b0;
    check("b2b_done", 32'(frame_done), 32'd1);
    check("b2b_busy", 32'(busy), 32'd0);
    wait_idle(0);

    // Random ready and inputs scrambled during frames.
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      randomize_inputs();
      pulse_start();
      wait_idle(1);
    end
    ready_mode = 0;

    // Single reserved byte build: 11-byte frame, frame_done at N+12.
    begin
      logic [7:0] f[$];
      randomize_inputs();
      @(posedge clk); #1;
      start1 = 1'b1;
      build_frame(8'hA5, 1, f);
      @(posedge clk); #1 start1 = 1'b0;
      for (int i = 0; i < 11; i++) begin
        check("rsv1_byte", {23'd0, valid1, data1}, {23'd0, 1'b1, f[i]});
        check("rsv1_done_low", 32'(frame_done1), 32'd0);
        @(posedge clk); #1;
      end
      check("rsv1_done", 32'(frame_done1), 32'd1);
      check("rsv1_busy", 32'(busy1), 32'd0);
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/frame_encoder.md
# frame_encoder

Serialises one control frame per request into a byte stream for the PC-to-drone UART link. Frame order: STX1 (0xFF), STX2 (0x5A), CH1–CH4, OFF1–OFF4, then six reserved bytes, for 16 bytes total. The block snapshots the channel and offset values at frame start. It feeds the byte-level UART transmitter through a valid/ready handshake, and its output is byte-compatible with the frame decoder on the receiving side.

## Interface

Parameters:
- STX1_BYTE, 8'hFF: first sync byte.
- STX2_BYTE, 8'h5A: second sync byte.
- RSV_BYTE, 8'h00: value sent in every reserved slot.
- RSV_COUNT, 6: number of reserved bytes; legal range 1–15.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: frame request; sampled only in S_IDLE.
- sink_CH1data … sink_CH4data, input, 8 each: channel values.
- sink_offset1data … sink_offset4data, input, 8 each: offset values.
- source_ready, input, 1: transmitter can accept a byte this cycle.
- source_data_valid, output, 1: source_data holds a frame byte.
- source_data, output, 8: current frame byte.
- busy, output, 1: high whenever the state is not S_IDLE.
- frame_done, output, 1: one-cycle pulse when the final byte transfers.

## Operation

- Reset values: state = S_IDLE, source_data_valid = 0, source_data = 0, busy = 0, frame_done = 0, reserved counter = 0, snapshot registers = 0.
- States, in order: S_IDLE, S_STX1, S_STX2, S_CH1, S_CH2, S_CH3, S_CH4, S_OFF1, S_OFF2, S_OFF3, S_OFF4, S_RSV. Any unused encoding returns to S_IDLE with reset values.
- S_IDLE with start = 1:
  - Capture all eight input bytes into snapshot registers.
  - Next state is S_STX1, with source_data = STX1_BYTE and source_data_valid = 1.
- S_IDLE with start = 0: remain in S_IDLE.
- Transfer: a byte transfers in any cycle where source_data_valid && source_ready.
  - On transfer, advance to the next state and load its byte in the same edge.
  - Without a transfer, hold state, source_data and source_data_valid unchanged (AXI-stream style; data never changes while valid is high and not accepted).
- Channel and offset bytes always come from the snapshot. Input changes during a frame have no effect until the next start.
- S_RSV sends RSV_BYTE RSV_COUNT times, using a 4-bit counter that runs 0 to RSV_COUNT−1.
- On the transfer of the last reserved byte:
  - Next state is S_IDLE; source_data_valid = 0; counter = 0.
  - frame_done = 1 for exactly one cycle.
- start while busy is ignored. It is not queued.
- start in the cycle frame_done is asserted is accepted: the block is in S_IDLE that cycle, so back-to-back frames have no idle gap beyond that cycle.
- reset mid-frame aborts immediately: valid drops next cycle and the partial frame is abandoned. The receiver resynchronises on the next STX pair.
- source_ready is ignored while source_data_valid = 0.

## Timing

- start at cycle N (in S_IDLE) gives source_data_valid = 1 with source_data = STX1_BYTE at N+1.
- With source_ready held high, one byte transfers per cycle.
  - The frame occupies cycles N+1 to N+16 for the default RSV_COUNT = 6.
  - frame_done is high at N+17; busy is high N+1 to N+16.
- Each cycle of source_ready = 0 while valid extends the frame by one cycle.
- All outputs are registered. There is no combinational path from source_ready or start to any output.

## Structure

- Shared package, frame_pkg:
  - sync byte constants 8'hFF and 8'h5A;
  - frame length = 16 and payload byte count = 8;
  - the state encoding localparams, shared with the decoder so both sides agree on order.
- One natural sub-module, frame_snapshot: an 8×8-bit register bank with load enable, indexed by a 3-bit payload selector, outputting the selected byte. The encoder FSM drives the load and the selector.
- Everything else (FSM, reserved counter, output registers) stays in frame_encoder.

## Test plan

1. Reset, then start pulse with CH = 10, 20, 30, 40 (hex) and OFF = 01, 02, 03, 04, source_ready always 1 → bytes FF 5A 10 20 30 40 01 02 03 04 00 00 00 00 00 00 on consecutive cycles N+1…N+16; frame_done at N+17 only.
2. Same frame with source_ready low on alternate cycles → identical 16-byte sequence; source_data stable while valid && !ready; frame_done after the 16th transfer.
3. start pulsed again at byte 5, and CH1 changed to 0x77 mid-frame → second start ignored; the frame still carries CH1 = 0x10; a later start sends 0x77.
4. reset asserted after byte 7 transfers → next cycle valid = 0, busy = 0, state S_IDLE; a new start gives a clean frame beginning with FF.
5. start held high continuously with ready = 1 → back-to-back frames, one S_IDLE cycle between them (coincident with frame_done), each exactly 16 bytes.
6. RSV_COUNT = 1 build → 11-byte frame ending in a single RSV_BYTE; frame_done at N+12.
